// File: rtl/decoder_scan_if.sv
// Bus bundle for decoder_scan: control/select inputs and registered decode outputs.
// The master modport drives the controls; the slave modport (the decoder) drives F/idx/wrap.
interface decoder_scan_if #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8
);
  localparam int unsigned N = 2 ** SEL_W;

  logic               en_n;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       F;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (
    output en_n, mode, sel, dwell,
    input  F, idx, wrap
  );

  modport slave (
    input  en_n, mode, sel, dwell,
    output F, idx, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// Active-low N-way decoder with direct-select and auto-scan modes.
// All outputs are registered; scan steps may optionally be separated by one blank cycle.
module decoder_scan #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned BBM     = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);
  localparam int unsigned N = 2 ** SEL_W;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDirect = 2'd1;
  localparam logic [1:0] StScan   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [N-1:0]       f_q, f_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               blank_q, blank_d;
  logic [SEL_W-1:0]   next_idx;

  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
    decode = ~(N'(1) << i);
  endfunction

  // Natural wrap of the SEL_W-bit adder takes N-1 back to 0.
  assign next_idx = idx_q + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    blank_d = 1'b0;
    if (bus.en_n) begin
      state_d = StIdle;
      f_d     = '1;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (!bus.mode) begin
      state_d = StDirect;
      f_d     = decode(bus.sel);
      idx_d   = bus.sel;
      cnt_d   = '0;
    end else if (state_q != StScan) begin
      // Fresh scan entry: no wrap pulse even though idx reads 0.
      state_d = StScan;
      f_d     = decode('0);
      idx_d   = '0;
      cnt_d   = '0;
    end else if (blank_q) begin
      idx_d  = next_idx;
      f_d    = decode(next_idx);
      wrap_d = (next_idx == '0);
      cnt_d  = '0;
    end else if (cnt_q >= bus.dwell) begin
      cnt_d = '0;
      if (BBM != 0) begin
        // idx holds during the blank; it moves on the following cycle.
        blank_d = 1'b1;
        f_d     = '1;
      end else begin
        idx_d  = next_idx;
        f_d    = decode(next_idx);
        wrap_d = (next_idx == '0);
      end
    end else begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      f_q     <= '1;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
    end
  end

  assign bus.F    = f_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: one instance without and one with the blank cycle,
// both driven from the same control inputs.
module tb_decoder_scan;
  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  decoder_scan_if #(.SEL_W(2), .DWELL_W(8)) bus0 ();
  decoder_scan_if #(.SEL_W(2), .DWELL_W(8)) bus1 ();

  decoder_scan #(.SEL_W(2), .DWELL_W(8), .BBM(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  decoder_scan #(.SEL_W(2), .DWELL_W(8), .BBM(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en_n, input logic mode, input logic [1:0] sel,
                       input logic [7:0] dwell);
    bus0.en_n = en_n;  bus0.mode = mode;  bus0.sel = sel;  bus0.dwell = dwell;
    bus1.en_n = en_n;  bus1.mode = mode;  bus1.sel = sel;  bus1.dwell = dwell;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 2'd2, 8'd0);
    step();
    step();
    nvec++;
    if (bus0.F !== 4'b1111 || bus0.idx !== 2'd0 || bus0.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reset dut0 got F=%b idx=%0d wrap=%b want 1111/0/0",
               bus0.F, bus0.idx, bus0.wrap);
    end
    nvec++;
    if (bus1.F !== 4'b1111 || bus1.idx !== 2'd0 || bus1.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reset dut1 got F=%b idx=%0d wrap=%b want 1111/0/0",
               bus1.F, bus1.idx, bus1.wrap);
    end
    drive(1'b1, 1'b0, 2'd0, 8'd0);
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_direct();
    logic [3:0] exp_f [4];
    exp_f = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 1'b0, 2'(s), 8'd5);
      nvec++;
      if (bus0.F !== (s == 0 ? 4'b1111 : exp_f[s-1])) begin
        nerr++;
        $display("FAIL direct latency sel=%0d got F=%b before edge", s, bus0.F);
      end
      step();
      nvec++;
      if (bus0.F !== exp_f[s] || bus0.idx !== 2'(s) || bus0.wrap !== 1'b0) begin
        nerr++;
        $display("FAIL direct dut0 sel=%0d got F=%b idx=%0d want F=%b idx=%0d",
                 s, bus0.F, bus0.idx, exp_f[s], s);
      end
      nvec++;
      if (bus1.F !== exp_f[s] || bus1.idx !== 2'(s)) begin
        nerr++;
        $display("FAIL direct dut1 sel=%0d got F=%b idx=%0d want F=%b idx=%0d",
                 s, bus1.F, bus1.idx, exp_f[s], s);
      end
    end
  endtask

  task automatic test_disable(input string tag);
    drive(1'b1, 1'b1, 2'd3, 8'd0);
    step();
    nvec++;
    if (bus0.F !== 4'b1111 || bus0.idx !== 2'd0 || bus0.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL disable %s got F=%b idx=%0d wrap=%b want 1111/0/0",
               tag, bus0.F, bus0.idx, bus0.wrap);
    end
  endtask

  task automatic test_scan();
    logic [1:0] exp_idx [13];
    logic [3:0] exp_f;
    exp_idx = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                2'd3, 2'd3, 2'd3, 2'd0};
    drive(1'b0, 1'b1, 2'd3, 8'd2);
    for (int i = 0; i < 13; i++) begin
      step();
      exp_f = ~(4'b0001 << exp_idx[i]);
      nvec++;
      if (bus0.idx !== exp_idx[i] || bus0.F !== exp_f || bus0.wrap !== (i == 12)) begin
        nerr++;
        $display("FAIL scan cyc=%0d got idx=%0d F=%b wrap=%b want idx=%0d F=%b wrap=%b",
                 i, bus0.idx, bus0.F, bus0.wrap, exp_idx[i], exp_f, (i == 12));
      end
      if (i == 5) drive(1'b0, 1'b1, 2'd0, 8'd2);
    end
  endtask

  task automatic test_bbm();
    logic [3:0] exp_f [9];
    logic [1:0] exp_idx [9];
    exp_f   = '{4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111, 4'b0111,
                4'b1111, 4'b1110};
    exp_idx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    drive(1'b0, 1'b1, 2'd0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      nvec++;
      if (bus1.F !== exp_f[i] || bus1.idx !== exp_idx[i] || bus1.wrap !== (i == 8)) begin
        nerr++;
        $display("FAIL bbm cyc=%0d got F=%b idx=%0d wrap=%b want F=%b idx=%0d wrap=%b",
                 i, bus1.F, bus1.idx, bus1.wrap, exp_f[i], exp_idx[i], (i == 8));
      end
      nvec++;
      if (bus0.idx !== 2'(i % 4) || bus0.wrap !== (i == 4 || i == 8)) begin
        nerr++;
        $display("FAIL dwell0 cyc=%0d got idx=%0d wrap=%b want idx=%0d wrap=%b",
                 i, bus0.idx, bus0.wrap, i % 4, (i == 4 || i == 8));
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 2'd0, 8'd0);
    step();
    step();
    step();
    nvec++;
    if (bus0.idx !== 2'd2) begin
      nerr++;
      $display("FAIL async pre-reset got idx=%0d want 2", bus0.idx);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (bus0.F !== 4'b1111 || bus0.idx !== 2'd0 || bus0.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL async immediate got F=%b idx=%0d wrap=%b want 1111/0/0",
               bus0.F, bus0.idx, bus0.wrap);
    end
    step();
    nvec++;
    if (bus0.F !== 4'b1111 || bus0.idx !== 2'd0 || bus1.F !== 4'b1111) begin
      nerr++;
      $display("FAIL async held got F0=%b idx0=%0d F1=%b want 1111/0/1111",
               bus0.F, bus0.idx, bus1.F);
    end
    #4 rst_n = 1'b1;
    step();
    nvec++;
    if (bus0.F !== 4'b1110 || bus0.idx !== 2'd0 || bus0.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL async restart got F=%b idx=%0d wrap=%b want 1110/0/0",
               bus0.F, bus0.idx, bus0.wrap);
    end
    nvec++;
    if (bus1.F !== 4'b1110 || bus1.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL async restart bbm got F=%b wrap=%b want 1110/0", bus1.F, bus1.wrap);
    end
    step();
    nvec++;
    if (bus0.idx !== 2'd1 || bus0.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL async second got idx=%0d wrap=%b want 1/0", bus0.idx, bus0.wrap);
    end
  endtask

  task automatic test_live_dwell();
    logic [1:0] exp_idx [9];
    exp_idx = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    drive(1'b0, 1'b1, 2'd0, 8'd10);
    for (int i = 0; i < 7; i++) step();
    nvec++;
    if (bus0.idx !== 2'd0) begin
      nerr++;
      $display("FAIL live hold got idx=%0d want 0", bus0.idx);
    end
    drive(1'b0, 1'b1, 2'd0, 8'd3);
    for (int i = 0; i < 9; i++) begin
      step();
      nvec++;
      if (bus0.idx !== exp_idx[i]) begin
        nerr++;
        $display("FAIL live cyc=%0d got idx=%0d want %0d", i, bus0.idx, exp_idx[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 2'd0, 8'd50);
    step();
    step();
    drive(1'b0, 1'b0, 2'd2, 8'd50);
    step();
    nvec++;
    if (bus0.F !== 4'b1011 || bus0.idx !== 2'd2 || bus1.F !== 4'b1011) begin
      nerr++;
      $display("FAIL abandon got F0=%b idx0=%0d F1=%b want 1011/2/1011",
               bus0.F, bus0.idx, bus1.F);
    end
    drive(1'b0, 1'b1, 2'd2, 8'd0);
    step();
    nvec++;
    if (bus0.F !== 4'b1110 || bus0.idx !== 2'd0 || bus0.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reenter got F=%b idx=%0d wrap=%b want 1110/0/0",
               bus0.F, bus0.idx, bus0.wrap);
    end
    step();
    nvec++;
    if (bus1.F !== 4'b1111 || bus1.idx !== 2'd0) begin
      nerr++;
      $display("FAIL reenter blank got F=%b idx=%0d want 1111/0", bus1.F, bus1.idx);
    end
    drive(1'b0, 1'b0, 2'd3, 8'd0);
    step();
    nvec++;
    if (bus1.F !== 4'b0111 || bus1.idx !== 2'd3) begin
      nerr++;
      $display("FAIL blank abandon got F=%b idx=%0d want 0111/3", bus1.F, bus1.idx);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_direct();
    test_disable("direct");
    test_scan();
    test_disable("scan");
    test_bbm();
    test_disable("bbm");
    test_async_reset();
    test_disable("post-reset");
    test_live_dwell();
    test_back_to_back();
    test_disable("final");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 2, select width; output count N = 2**SEL_W.
REQ-002 SHALL have parameter DWELL_W, default 8, width of dwell count.
REQ-003 SHALL have parameter BBM, default 0; 1 = insert one blank cycle between scan steps.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en_n  input  1  enable, active-low; 1 = all outputs inactive.
REQ-007 SHALL have port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 SHALL have port sel  input  SEL_W  index decoded in direct mode.
REQ-009 SHALL have port dwell  input  DWELL_W  scan hold; each index held dwell+1 cycles.
REQ-010 SHALL have port F  output  N  decoded lines, active-low, registered.
REQ-011 SHALL have port idx  output  SEL_W  index currently driven low, registered.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse when scan index returns to 0.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, DIRECT, SCAN.
REQ-014 SHALL evaluate transitions each clk edge, priority: en_n=1 -> IDLE; else mode=0 -> DIRECT; else mode=1 -> SCAN.
REQ-015 SHALL, in IDLE, drive F all ones, hold idx at 0, clear dwell counter, wrap 0.
REQ-016 SHALL, in DIRECT, drive F[sel] low and all other bits high, idx = sel, with exactly one cycle latency from sel/en_n/mode to F.
REQ-017 SHALL, on entering SCAN from IDLE or DIRECT, start at idx 0 with dwell counter 0; F[0] low on the first SCAN cycle.
REQ-018 SHALL, in SCAN, increment dwell counter each cycle and advance idx when counter >= dwell (live compare), then clear counter.
REQ-019 SHALL treat dwell = 0 as advance every cycle.
REQ-020 SHALL, if dwell is lowered below the current count mid-step, advance on the next cycle.
REQ-021 SHALL wrap idx from N-1 to 0 and assert wrap for exactly the cycle idx first reads 0 after wrap; not on SCAN entry.
REQ-022 SHALL, with BBM=1, drive F all ones for one cycle between every scan step including wrap; idx and wrap update with the cycle after the blank; the blank cycle does not count toward dwell.
REQ-023 SHALL guarantee F has at most one zero bit in every cycle, in every state.
REQ-024 SHALL ignore sel in SCAN and ignore dwell in DIRECT and IDLE.
REQ-025 SHALL, on SCAN->DIRECT or ->IDLE, abandon the scan step immediately, without completing dwell or blank.
REQ-026 SHALL size the dwell counter DWELL_W bits; no overflow is possible since it clears at dwell.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force state IDLE, F all ones, idx 0, wrap 0, dwell counter 0, blank flag 0.
REQ-028 SHALL resume on the first clk edge after rst_n deasserts, evaluating REQ-014 on that edge.
REQ-029 SHALL hold the reset values whenever rst_n is low, regardless of clk or other inputs.

Verification
REQ-030 SHALL cover direct decode: SEL_W=2, en_n=0, mode=0, sel=0..3 one per cycle -> F = 1110,1101,1011,0111 each one cycle later, idx matches.
REQ-031 SHALL cover disable: en_n=1 in any state -> next cycle F=1111, idx=0, wrap=0.
REQ-032 SHALL cover scan: mode=1, dwell=2 -> idx 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap high only on the cycle idx returns to 0.
REQ-033 SHALL cover dwell=0 and BBM=1: mode=1 -> F = 1110,1111,1101,1111,1011,1111,0111,1111,1110 repeating.
REQ-034 SHALL cover async reset mid-scan: rst_n low between clk edges at idx=2 -> F=1111, idx=0 immediately; after release with mode=1, scan restarts at idx 0 with no wrap pulse.
REQ-035 SHALL cover live dwell change: dwell=10, count at 6, dwell set to 3 -> idx advances next cycle; subsequent steps hold 4 cycles each.
